// File: rtl/vga_digit_renderer_if.sv
// Video bundle between the sync generator and the digit renderer.
// master drives timing, coordinates and the BCD time; slave returns aligned syncs and colour.
interface vga_digit_renderer_if;
    logic        hsync_in;
    logic        vsync_in;
    logic        activevideo_in;
    logic [9:0]  x_px;
    logic [9:0]  y_px;
    logic [23:0] bcd_time;
    logic        hsync;
    logic        vsync;
    logic [5:0]  rgb;

    modport master (
        output hsync_in, vsync_in, activevideo_in, x_px, y_px, bcd_time,
        input  hsync, vsync, rgb
    );

    modport slave (
        input  hsync_in, vsync_in, activevideo_in, x_px, y_px, bcd_time,
        output hsync, vsync, rgb
    );
endinterface

// File: rtl/vga_digit_renderer.sv
// Draws HH:MM:SS in a scaled 5x7 font; 3-stage pipeline (decode, font lookup, pixel select).
// Define VGA_DIGIT_COLON_EN to get blinking colons; otherwise colon cells stay unlit.
module vga_digit_renderer #(
    parameter int          X0         = 64,
    parameter int          Y0         = 200,
    parameter int          SCALE_LOG2 = 3,
    parameter logic [5:0]  FG         = 6'b111111,
    parameter logic [5:0]  BG         = 6'b000001,
    parameter int          FRAME_HALF = 36
) (
    input  logic                 px_clk,
    input  logic                 reset,
    vga_digit_renderer_if.slave  vid
);
    localparam int          CELL = 8 << SCALE_LOG2;
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + 8 * CELL);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + CELL);

    function automatic logic [4:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
        logic [34:0] g;
        case (d)
            4'd0:    g = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
            4'd1:    g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            4'd2:    g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
            4'd3:    g = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            4'd4:    g = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            4'd5:    g = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            4'd6:    g = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            4'd7:    g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            4'd8:    g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            4'd9:    g = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            default: g = '0;
        endcase
        case (r)
            3'd0:    return g[34:30];
            3'd1:    return g[29:25];
            3'd2:    return g[24:20];
            3'd3:    return g[19:15];
            3'd4:    return g[14:10];
            3'd5:    return g[9:5];
            3'd6:    return g[4:0];
            default: return 5'b0;
        endcase
    endfunction

    // frame-boundary detection and per-frame time snapshot
    logic        vs_prev;
    logic        vs_fall;
    logic [23:0] snap;

    assign vs_fall = vs_prev & ~vid.vsync_in;

    always_ff @(posedge px_clk) begin
        if (reset) begin
            vs_prev <= 1'b0;
            snap    <= 24'h000000;
        end else begin
            vs_prev <= vid.vsync_in;
            if (vs_fall)
                snap <= vid.bcd_time;
        end
    end

`ifdef VGA_DIGIT_COLON_EN
    localparam int FW = (FRAME_HALF > 1) ? $clog2(FRAME_HALF) : 1;
    logic [FW-1:0] frame_cnt;
    logic          colon_phase;

    always_ff @(posedge px_clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            colon_phase <= 1'b1;
        end else if (vs_fall) begin
            if (frame_cnt == FW'(FRAME_HALF - 1)) begin
                frame_cnt   <= '0;
                colon_phase <= ~colon_phase;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end
`endif

    // stage 1: field test and cell/column/row decode
    logic [10:0] x_ext, y_ext, dx, dy;
    logic [2:0]  cell_d, col_d, row_d;
    logic        in_field_d;

    always_comb begin
        x_ext      = {1'b0, vid.x_px};
        y_ext      = {1'b0, vid.y_px};
        dx         = x_ext - X_LO;
        dy         = y_ext - Y_LO;
        cell_d     = 3'(dx >> (SCALE_LOG2 + 3));
        col_d      = 3'(dx >> SCALE_LOG2);
        row_d      = 3'(dy >> SCALE_LOG2);
        in_field_d = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
    end

    logic       s1_hs, s1_vs, s1_act, s1_in;
    logic [2:0] s1_cell, s1_col, s1_row;

    always_ff @(posedge px_clk) begin
        if (reset) begin
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_act  <= 1'b0;
            s1_in   <= 1'b0;
            s1_cell <= '0;
            s1_col  <= '0;
            s1_row  <= '0;
        end else begin
            s1_hs   <= vid.hsync_in;
            s1_vs   <= vid.vsync_in;
            s1_act  <= vid.activevideo_in;
            s1_in   <= in_field_d;
            s1_cell <= cell_d;
            s1_col  <= col_d;
            s1_row  <= row_d;
        end
    end

    // stage 2: pick the digit for this cell and fetch its glyph row
    logic [3:0] digit;
    logic       is_colon;
    logic [4:0] colon_bits;
    logic [4:0] row_bits;

    always_comb begin
        digit    = 4'hF;
        is_colon = 1'b0;
        case (s1_cell)
            3'd0:    digit = snap[23:20];
            3'd1:    digit = snap[19:16];
            3'd3:    digit = snap[15:12];
            3'd4:    digit = snap[11:8];
            3'd6:    digit = snap[7:4];
            3'd7:    digit = snap[3:0];
            default: is_colon = 1'b1;
        endcase
`ifdef VGA_DIGIT_COLON_EN
        colon_bits = (colon_phase && (s1_row == 3'd2 || s1_row == 3'd4)) ? 5'b00100 : 5'b00000;
`else
        colon_bits = 5'b00000;
`endif
        row_bits = is_colon ? colon_bits : glyph_row(digit, s1_row);
    end

    logic       s2_hs, s2_vs, s2_act, s2_in;
    logic [2:0] s2_col;
    logic [4:0] s2_bits;

    always_ff @(posedge px_clk) begin
        if (reset) begin
            s2_hs   <= 1'b1;
            s2_vs   <= 1'b1;
            s2_act  <= 1'b0;
            s2_in   <= 1'b0;
            s2_col  <= '0;
            s2_bits <= '0;
        end else begin
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
            s2_act  <= s1_act;
            s2_in   <= s1_in;
            s2_col  <= s1_col;
            s2_bits <= row_bits;
        end
    end

    // stage 3: padding to 8 columns keeps cols 5..7 dark without a range check
    logic [7:0] px_bits;
    logic       lit;

    always_comb begin
        px_bits = {s2_bits, 3'b000};
        lit     = s2_in && px_bits[3'd7 - s2_col];
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            vid.hsync <= 1'b1;
            vid.vsync <= 1'b1;
            vid.rgb   <= 6'b0;
        end else begin
            vid.hsync <= s2_hs;
            vid.vsync <= s2_vs;
            vid.rgb   <= s2_act ? (lit ? FG : BG) : 6'b0;
        end
    end
endmodule
